// File: rtl/exmem_pkg.sv
// Shared definitions for the external-memory loader and read path:
// controller states and default word/address widths.
package exmem_pkg;

  localparam int unsigned EXMEM_DATA_WIDTH = 8;
  localparam int unsigned EXMEM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/exmem_sum.sv
// Clearable modulo-2^DATA_WIDTH accumulator; clear takes priority over add.
module exmem_sum
  import exmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EXMEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/exmem_loader.sv
// Streams words into consecutive RAM addresses from a base, then reads the
// range back and compares checksums of written vs. read data.
module exmem_loader
  import exmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EXMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = EXMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    rd_issued_q, rd_issued_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   wsum, rsum;
  logic                    start_acc;
  logic                    beat_acc;

  assign start_acc = (state_q == IDLE) && start;
  assign beat_acc  = (state_q == WRITE) && in_valid;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    rd_issued_d = 1'b0;
    rd_valid_d  = rd_issued_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          addr_d  = base_addr;
          cnt_d   = length;
          error_d = 1'b0;
          // Empty transfer passes through CHECK so done still lands 2 cycles after start.
          state_d = (length == '0) ? CHECK : WRITE;
        end
      end
      WRITE: begin
        if (in_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            addr_d  = base_q;
            cnt_d   = len_q;
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        // Address is registered here, presented next cycle, data summed the cycle after.
        if (cnt_q != '0) begin
          raddr_d     = addr_q;
          addr_d      = addr_q + ADDR_ONE;
          cnt_d       = cnt_q - CNT_ONE;
          rd_issued_d = 1'b1;
        end else if (!rd_issued_q) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rsum != wsum) begin
          error_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      rd_issued_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      rd_issued_q <= rd_issued_d;
      rd_valid_q  <= rd_valid_d;
      error_q     <= error_d;
    end
  end

  exmem_sum #(.DATA_WIDTH(DATA_WIDTH)) u_wsum (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start_acc),
    .en    (beat_acc),
    .din   (in_data),
    .sum   (wsum)
  );

  exmem_sum #(.DATA_WIDTH(DATA_WIDTH)) u_rsum (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start_acc),
    .en    (rd_valid_q),
    .din   (mem_rdata),
    .sum   (rsum)
  );

  assign in_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_raddr = raddr_q;
  assign error     = error_q;

endmodule

// File: tb/tb_exmem_loader.sv
// Directed bench for exmem_loader paired with a 1-cycle-read dual-port RAM.
module tb_exmem_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:255];
  logic       corrupt = 1'b0;
  logic [7:0] beats [0:15];
  logic [7:0] raddr_log [0:255];
  logic [7:0] we_log [$];

  always #5 clk = ~clk;

  exmem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= (corrupt && mem_raddr == 8'h11) ? 8'h00 : ram[mem_raddr];
  end

  always @(negedge clk) begin
    if (mem_we) we_log.push_back(mem_waddr);
  end

  // Start in cycle 0, feed beats[] (optionally every other cycle), optional
  // second start pulse in cycle restart_c; cycle numbers are relative to start.
  task automatic do_xfer(input logic [7:0] b, input logic [8:0] len, input bit stall,
                         input int restart_c, output int done_cyc, output logic err_done,
                         output logic err_c1, output int busy_cnt, output int done_cnt);
    int bi;
    bi = 0;
    done_cyc = -1;
    err_done = 1'bx;
    err_c1 = 1'bx;
    busy_cnt = 0;
    done_cnt = 0;
    we_log.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = len; in_valid = 1'b0;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start = (c == restart_c);
      if (c == restart_c) begin
        base_addr = 8'h80; length = 9'd1;
      end
      if (bi < int'(len) && (!stall || (c % 2) == 1)) begin
        in_valid = 1'b1; in_data = beats[bi];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      raddr_log[c] = mem_raddr;
      if (busy) busy_cnt++;
      if (c == 1) err_c1 = error;
      if (in_valid && in_ready) bi++;
      if (done) begin
        done_cnt++; done_cyc = c; err_done = error;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, error} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, error});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int dc, bc, dn; logic ed, e1;
    for (int i = 0; i < 4; i++) beats[i] = 8'(i + 1);
    do_xfer(8'h10, 9'd4, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (dc !== 12) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 12", dc); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", ed); end
    n_checks++;
    if (we_log.size() !== 4) begin
      n_fail++; $display("FAIL basic_we_count: got %0d expected 4", we_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram[16 + i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL basic_ram[%0d]: got %h expected %h", 16 + i, ram[16 + i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_wrap;
    int dc, bc, dn; logic ed, e1;
    logic [7:0] exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
    beats[0] = 8'hAA; beats[1] = 8'hBB; beats[2] = 8'hCC;
    do_xfer(8'hFE, 9'd3, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (dc !== 10) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected 10", dc); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL wrap_error: got %b expected 0", ed); end
    n_checks++;
    if (we_log.size() !== 3) begin
      n_fail++; $display("FAIL wrap_we_count: got %0d expected 3", we_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (we_log[i] !== exp_a[i]) begin
          n_fail++; $display("FAIL wrap_waddr[%0d]: got %h expected %h", i, we_log[i], exp_a[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (raddr_log[5 + i] !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_raddr[%0d]: got %h expected %h", i, raddr_log[5 + i], exp_a[i]);
      end
    end
    n_checks++;
    if (ram[0] !== 8'hCC) begin n_fail++; $display("FAIL wrap_ram00: got %h expected cc", ram[0]); end
  endtask

  task automatic test_len0;
    int dc, bc, dn; logic ed, e1;
    do_xfer(8'h40, 9'd0, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (dc !== 2) begin n_fail++; $display("FAIL len0_done_cycle: got %0d expected 2", dc); end
    n_checks++;
    if (bc !== 2) begin n_fail++; $display("FAIL len0_busy_cycles: got %0d expected 2", bc); end
    n_checks++;
    if (we_log.size() !== 0) begin
      n_fail++; $display("FAIL len0_we_count: got %0d expected 0", we_log.size());
    end
    n_checks++;
    if (mem_raddr !== 8'h00) begin n_fail++; $display("FAIL len0_raddr: got %h expected 00", mem_raddr); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL len0_error: got %b expected 0", ed); end
  endtask

  task automatic test_corrupt;
    int dc, bc, dn; logic ed, e1;
    for (int i = 0; i < 4; i++) beats[i] = 8'(i + 1);
    corrupt = 1'b1;
    do_xfer(8'h10, 9'd4, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (ed !== 1'b1) begin n_fail++; $display("FAIL corrupt_error_at_done: got %b expected 1", ed); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL corrupt_error_held: got %b expected 1", error); end
    corrupt = 1'b0;
    beats[0] = 8'h09; beats[1] = 8'h08;
    do_xfer(8'h20, 9'd2, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (e1 !== 1'b0) begin n_fail++; $display("FAIL corrupt_error_cleared: got %b expected 0", e1); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL corrupt_rerun_error: got %b expected 0", ed); end
    n_checks++;
    if (dc !== 8) begin n_fail++; $display("FAIL corrupt_rerun_done_cycle: got %0d expected 8", dc); end
  endtask

  task automatic test_stall_restart;
    int dc, bc, dn; logic ed, e1;
    beats[0] = 8'h05; beats[1] = 8'h06; beats[2] = 8'h07;
    do_xfer(8'h30, 9'd3, 1'b1, 2, dc, ed, e1, bc, dn);
    n_checks++;
    if (dc !== 12) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 12", dc); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", dn); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL stall_error: got %b expected 0", ed); end
    n_checks++;
    if (we_log.size() !== 3) begin
      n_fail++; $display("FAIL stall_we_count: got %0d expected 3", we_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (we_log[i] !== 8'(8'h30 + i)) begin
          n_fail++; $display("FAIL stall_waddr[%0d]: got %h expected %h", i, we_log[i], 8'(8'h30 + i));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ram[48 + i] !== 8'(5 + i)) begin
        n_fail++; $display("FAIL stall_ram[%0d]: got %h expected %h", 48 + i, ram[48 + i], 8'(5 + i));
      end
    end
  endtask

  task automatic test_reset_mid;
    int dc, bc, dn, late_done; logic ed, e1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h60; length = 9'd4; in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 8'(c * 17);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, error} !== 29'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h expected 0",
               {in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, busy, done, error});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    late_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) late_done++;
    end
    n_checks++;
    if (late_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", late_done); end
    for (int i = 0; i < 4; i++) beats[i] = 8'(8'hA0 + i);
    do_xfer(8'h60, 9'd4, 1'b0, -1, dc, ed, e1, bc, dn);
    n_checks++;
    if (dc !== 12) begin n_fail++; $display("FAIL midrst_rerun_done_cycle: got %0d expected 12", dc); end
    n_checks++;
    if (ed !== 1'b0) begin n_fail++; $display("FAIL midrst_rerun_error: got %b expected 0", ed); end
    n_checks++;
    if (ram[99] !== 8'hA3) begin n_fail++; $display("FAIL midrst_rerun_ram: got %h expected a3", ram[99]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_corrupt();
    test_stall_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
